// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running display timing with signed coordinates, blanking at negative values
module video_timing_gen #(
  parameter int HRES     = 640,
  parameter int VRES     = 480,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int COORDSPC = 16,
  parameter int FCNTW    = 16
) (
  input  logic                       video_clk_pix,
  input  logic                       video_rst_n,
  output logic signed [COORDSPC-1:0] sx,
  output logic signed [COORDSPC-1:0] sy,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       video_enable,
  output logic                       frame_start,
  output logic                       line_start,
  output logic [FCNTW-1:0]           frame_num
);
  typedef logic signed [COORDSPC-1:0] coord_t;
  localparam int HB  = H_FP + H_SYNC + H_BP;
  localparam int VB  = V_FP + V_SYNC + V_BP;
  localparam int LIM = 2 ** (COORDSPC - 1);
  localparam coord_t H_STA  = coord_t'(-HB);
  localparam coord_t HS_STA = coord_t'(H_FP - HB);
  localparam coord_t HS_END = coord_t'(H_FP + H_SYNC - HB);
  localparam coord_t HA_END = coord_t'(HRES - 1);
  localparam coord_t V_STA  = coord_t'(-VB);
  localparam coord_t VS_STA = coord_t'(V_FP - VB);
  localparam coord_t VS_END = coord_t'(V_FP + V_SYNC - VB);
  localparam coord_t VA_END = coord_t'(VRES - 1);
  localparam logic H_ACT = H_POL != 0;
  localparam logic V_ACT = V_POL != 0;
  if (HB > LIM || HRES > LIM || VB > LIM || VRES > LIM) begin : g_width_check
    $error("COORDSPC too narrow for the configured timing");
  end
  coord_t sx_n, sy_n;
  logic   eol;
  // next-pixel counters; outputs decode these so every register describes the same pixel
  always_comb begin
    eol  = sx == HA_END;
    sx_n = eol ? H_STA : sx + coord_t'(1);
    sy_n = eol ? (sy == VA_END ? V_STA : sy + coord_t'(1)) : sy;
  end
  // counters and registered decode; reset parks at the last pixel so the first edge starts a frame
  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      sx           <= HA_END;
      sy           <= VA_END;
      hsync        <= !H_ACT;
      vsync        <= !V_ACT;
      video_enable <= 1'b0;
      frame_start  <= 1'b0;
      line_start   <= 1'b0;
      frame_num    <= '0;
    end else begin
      sx           <= sx_n;
      sy           <= sy_n;
      hsync        <= (sx_n >= HS_STA && sx_n < HS_END) == H_ACT;
      vsync        <= (sy_n >= VS_STA && sy_n < VS_END) == V_ACT;
      video_enable <= !sx_n[COORDSPC-1] && !sy_n[COORDSPC-1];
      line_start   <= sx_n == H_STA;
      frame_start  <= sx_n == H_STA && sy_n == V_STA;
      if (sx_n == H_STA && sy_n == V_STA) frame_num <= frame_num + FCNTW'(1);
    end
  end
endmodule
